// File: rtl/lpc_host_if.sv
// lpc_host_if: request/response handshake and LPC pin bundle.
// master = the cycle generator, slave = requester plus peripheral side.
interface lpc_host_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_data;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_status;
   logic [3:0]  lpc_ad_in;
   logic [3:0]  lpc_ad_out;
   logic        lpc_ad_oe;
   logic        lpc_frame;

   modport master (
      input  req_valid, req_write, req_addr, req_data, lpc_ad_in,
      output req_ready, rsp_valid, rsp_data, rsp_status,
             lpc_ad_out, lpc_ad_oe, lpc_frame
   );

   modport slave (
      output req_valid, req_write, req_addr, req_data, lpc_ad_in,
      input  req_ready, rsp_valid, rsp_data, rsp_status,
             lpc_ad_out, lpc_ad_oe, lpc_frame
   );
endinterface

// File: rtl/lpc_host.sv
// lpc_host: LPC IO read/write cycle generator (bus initiator).
// Outputs are registered from a decode of the next state.
module lpc_host #(
   parameter int SYNC_TIMEOUT = 8,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic       lpc_clock,
   input  logic       lpc_reset,
   lpc_host_if.master bus
);

   typedef enum logic [4:0] {
      S_IDLE, S_START, S_CTDIR,
      S_ADDR3, S_ADDR2, S_ADDR1, S_ADDR0,
      S_WDATA0, S_WDATA1, S_TAR0, S_TAR1,
      S_SYNC, S_RDATA0, S_RDATA1,
      S_PTAR0, S_PTAR1, S_DONE,
      S_ABORT, S_ABEND
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic        r_write;
   logic [15:0] r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata;
   logic [7:0]  r_inv;
   logic [7:0]  r_wait;
   logic [7:0]  w_inv_nx;
   logic [7:0]  w_wait_nx;
   logic [7:0]  w_inv_inc;
   logic [7:0]  w_wait_inc;
   logic [1:0]  r_acnt;
   logic [1:0]  w_acnt_nx;
   logic [1:0]  r_st;
   logic [1:0]  w_st_nx;
   logic        r_frame;
   logic        r_oe;
   logic        r_ready;
   logic        r_valid;
   logic [3:0]  r_ad;
   logic [7:0]  r_rsp_data;
   logic [1:0]  r_rsp_st;
   logic        w_frame;
   logic        w_oe;
   logic        w_ready;
   logic        w_valid;
   logic [3:0]  w_ad;
   logic        w_accept;
   logic        w_sync_ok;
   logic        w_sync_err;
   logic        w_sync_wait;
   logic [3:0]  w_lad;

   assign w_lad       = bus.lpc_ad_in;
   assign w_accept    = (r_state == S_IDLE) & bus.req_valid;
   assign w_sync_ok   = (w_lad == 4'h0);
   assign w_sync_err  = (w_lad == 4'hA);
   assign w_sync_wait = (w_lad == 4'h5) | (w_lad == 4'h6);
   assign w_inv_inc   = (r_inv == 8'hFF) ? r_inv : r_inv + 8'd1;
   assign w_wait_inc  = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;

   assign bus.lpc_frame  = r_frame;
   assign bus.lpc_ad_oe  = r_oe;
   assign bus.lpc_ad_out = r_ad;
   assign bus.req_ready  = r_ready;
   assign bus.rsp_valid  = r_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_status = r_rsp_st;

   // Next state, SYNC counters, abort hold counter and latched status.
   always_comb begin
      w_state_nx = r_state;
      w_inv_nx   = r_inv;
      w_wait_nx  = r_wait;
      w_acnt_nx  = r_acnt;
      w_st_nx    = r_st;
      unique case (r_state)
         S_IDLE:   if (w_accept) w_state_nx = S_START;
         S_START: begin
            w_state_nx = S_CTDIR;
            w_inv_nx   = '0;
            w_wait_nx  = '0;
            w_acnt_nx  = '0;
            w_st_nx    = 2'b00;
         end
         S_CTDIR:  w_state_nx = S_ADDR3;
         S_ADDR3:  w_state_nx = S_ADDR2;
         S_ADDR2:  w_state_nx = S_ADDR1;
         S_ADDR1:  w_state_nx = S_ADDR0;
         S_ADDR0:  w_state_nx = r_write ? S_WDATA0 : S_TAR0;
         S_WDATA0: w_state_nx = S_WDATA1;
         S_WDATA1: w_state_nx = S_TAR0;
         S_TAR0:   w_state_nx = S_TAR1;
         S_TAR1:   w_state_nx = S_SYNC;
         S_SYNC: begin
            unique case (1'b1)
               w_sync_ok: begin
                  w_st_nx    = 2'b00;
                  w_state_nx = r_write ? S_PTAR0 : S_RDATA0;
               end
               w_sync_err: begin
                  w_st_nx    = 2'b01;
                  w_state_nx = r_write ? S_PTAR0 : S_RDATA0;
               end
               w_sync_wait: begin
                  w_wait_nx = w_wait_inc;
                  w_inv_nx  = '0;
                  if (w_wait_inc >= 8'(WAIT_TIMEOUT)) begin
                     w_st_nx    = 2'b10;
                     w_state_nx = S_ABORT;
                  end
               end
               default: begin
                  w_inv_nx = w_inv_inc;
                  if (w_inv_inc >= 8'(SYNC_TIMEOUT)) begin
                     w_st_nx    = 2'b10;
                     w_state_nx = S_ABORT;
                  end
               end
            endcase
         end
         S_RDATA0: w_state_nx = S_RDATA1;
         S_RDATA1: w_state_nx = S_PTAR0;
         S_PTAR0:  w_state_nx = S_PTAR1;
         S_PTAR1:  w_state_nx = S_DONE;
         S_DONE:   w_state_nx = S_IDLE;
         S_ABORT: begin
            if (r_acnt == 2'd3) w_state_nx = S_ABEND;
            else                w_acnt_nx  = r_acnt + 2'd1;
         end
         S_ABEND:  w_state_nx = S_DONE;
         default:  w_state_nx = S_IDLE;
      endcase
   end

   // Pin and handshake values for the state being entered.
   always_comb begin
      w_frame = 1'b1;
      w_oe    = 1'b0;
      w_ad    = 4'hF;
      w_ready = 1'b0;
      w_valid = 1'b0;
      unique case (w_state_nx)
         S_IDLE:   w_ready = 1'b1;
         S_START: begin
            w_frame = 1'b0;
            w_oe    = 1'b1;
            w_ad    = 4'h0;
         end
         S_CTDIR: begin
            w_oe = 1'b1;
            w_ad = {2'b00, r_write, 1'b0};
         end
         S_ADDR3: begin
            w_oe = 1'b1;
            w_ad = r_addr[15:12];
         end
         S_ADDR2: begin
            w_oe = 1'b1;
            w_ad = r_addr[11:8];
         end
         S_ADDR1: begin
            w_oe = 1'b1;
            w_ad = r_addr[7:4];
         end
         S_ADDR0: begin
            w_oe = 1'b1;
            w_ad = r_addr[3:0];
         end
         S_WDATA0: begin
            w_oe = 1'b1;
            w_ad = r_wdata[3:0];
         end
         S_WDATA1: begin
            w_oe = 1'b1;
            w_ad = r_wdata[7:4];
         end
         S_TAR0:   w_oe = 1'b1;
         S_DONE:   w_valid = 1'b1;
         S_ABORT: begin
            w_frame = 1'b0;
            w_oe    = 1'b1;
         end
         S_ABEND:  w_oe = 1'b1;
         default: begin
            w_frame = 1'b1;
            w_oe    = 1'b0;
         end
      endcase
   end

   // State, counters and registered pin outputs.
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         r_state <= S_IDLE;
         r_inv   <= '0;
         r_wait  <= '0;
         r_acnt  <= '0;
         r_st    <= 2'b00;
         r_frame <= 1'b1;
         r_oe    <= 1'b0;
         r_ad    <= 4'hF;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_inv   <= w_inv_nx;
         r_wait  <= w_wait_nx;
         r_acnt  <= w_acnt_nx;
         r_st    <= w_st_nx;
         r_frame <= w_frame;
         r_oe    <= w_oe;
         r_ad    <= w_ad;
         r_ready <= w_ready;
         r_valid <= w_valid;
      end
   end

   // Request latch, read-data capture and response registers.
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_rsp_data <= '0;
         r_rsp_st   <= 2'b00;
      end else begin
         if (w_accept) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_data;
         end
         if (r_state == S_START)  r_rdata      <= '0;
         if (r_state == S_RDATA0) r_rdata[3:0] <= w_lad;
         if (r_state == S_RDATA1) r_rdata[7:4] <= w_lad;
         if (w_state_nx == S_DONE) begin
            r_rsp_data <= (r_st == 2'b10) ? 8'h00 : r_rdata;
            r_rsp_st   <= r_st;
         end
      end
   end

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: random LPC IO cycles against a cycle-table model,
// with a scoreboard monitor checking responses and bus traces.
module tb_lpc_host;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   lpc_host_if u_if();

   lpc_host #(
      .SYNC_TIMEOUT(8),
      .WAIT_TIMEOUT(255)
   ) dut (
      .lpc_clock(clk),
      .lpc_reset(rst_n),
      .bus(u_if)
   );

   typedef struct {
      logic [7:0]        data;
      logic [1:0]        st;
      int                lat;
      logic [399:0]      fr;
      logic [399:0]      oe;
      logic [399:0]      rdy;
      logic [399:0][3:0] ad;
   } exp_t;

   exp_t sbq[$];
   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [3:0] per [400];

   bit m_act = 0;
   int m_k = 0;
   bit m_rdy_chk = 0;
   logic [399:0]      m_fr;
   logic [399:0]      m_oe;
   logic [399:0]      m_rdy;
   logic [399:0][3:0] m_ad;

   bit p_act = 0;
   int p_k = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
      end
   endtask

   // Reference: walk the peripheral's SYNC codes by the protocol rules,
   // then lay out the expected per-cycle pin table from START to DONE.
   function automatic exp_t model(input logic w, input logic [15:0] a,
                                  input logic [7:0] d);
      exp_t e;
      int ss, s, inv, wt;
      bit term, ab;
      logic [3:0] c;
      ss = w ? 10 : 8;
      s = 0; inv = 0; wt = 0; term = 0; ab = 0;
      e.st = 2'b00;
      while (!term && (ss + s) < 380) begin
         c = per[ss+s];
         s++;
         if (c == 4'h0) begin
            e.st = 2'b00; term = 1;
         end else if (c == 4'hA) begin
            e.st = 2'b01; term = 1;
         end else if (c == 4'h5 || c == 4'h6) begin
            wt++; inv = 0;
            if (wt >= 255) begin ab = 1; term = 1; end
         end else begin
            inv++;
            if (inv >= 8) begin ab = 1; term = 1; end
         end
      end
      e.fr = '1; e.oe = '0; e.rdy = '0; e.ad = '1;
      e.fr[0] = 1'b0; e.oe[0] = 1'b1; e.ad[0] = 4'h0;
      e.oe[1] = 1'b1; e.ad[1] = w ? 4'h2 : 4'h0;
      for (int i = 0; i < 4; i++) begin
         e.oe[2+i] = 1'b1;
         e.ad[2+i] = a[15-4*i -: 4];
      end
      if (w) begin
         e.oe[6] = 1'b1; e.ad[6] = d[3:0];
         e.oe[7] = 1'b1; e.ad[7] = d[7:4];
      end
      e.oe[ss-2] = 1'b1;
      if (ab) begin
         e.st = 2'b10;
         e.data = 8'h00;
         for (int j = 0; j < 4; j++) begin
            e.fr[ss+s+j] = 1'b0;
            e.oe[ss+s+j] = 1'b1;
         end
         e.oe[ss+s+4] = 1'b1;
         e.lat = ss + s + 5;
      end else begin
         e.data = w ? 8'h00 : {per[ss+s+1], per[ss+s]};
         e.lat = ss + s + (w ? 0 : 2) + 2;
      end
      return e;
   endfunction

   task automatic clr_per();
      for (int i = 0; i < 400; i++) per[i] = 4'hF;
   endtask

   task automatic issue(input logic w, input logic [15:0] a,
                        input logic [7:0] d, input bit junk);
      int n, c0;
      sbq.push_back(model(w, a, d));
      c0 = done_cnt;
      @(posedge clk); #1;
      u_if.req_valid = 1'b1;
      u_if.req_write = w;
      u_if.req_addr  = a;
      u_if.req_data  = d;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!u_if.req_ready && n < 1000);
      @(posedge clk); #1;
      if (junk) begin
         u_if.req_write = ~w;
         u_if.req_addr  = 16'($urandom);
         repeat (2) @(posedge clk);
         #1;
      end
      u_if.req_valid = 1'b0;
      n = 0;
      while (done_cnt == c0 && n < 800) begin
         @(negedge clk); #2;
         n++;
      end
      chk("rsp_seen", done_cnt - c0, 1);
   endtask

   // Peripheral: drives the prepared LAD table, indexed from START.
   initial begin
      u_if.lpc_ad_in = 4'hF;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            p_act = 0;
            u_if.lpc_ad_in = 4'hF;
         end else begin
            if (p_act) p_k++;
            if (!u_if.lpc_frame && u_if.lpc_ad_oe &&
                u_if.lpc_ad_out == 4'h0) begin
               p_act = 1; p_k = 0;
            end
            if (u_if.rsp_valid) p_act = 0;
            u_if.lpc_ad_in = (p_act && p_k < 400) ? per[p_k] : 4'hF;
         end
      end
   end

   // Monitor: records pins per cycle and checks each response.
   initial begin
      exp_t e;
      int first;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_act = 0;
            m_rdy_chk = 0;
         end else begin
            if (m_rdy_chk) begin
               chk("ready_after_done", u_if.req_ready, 1);
               chk("rsp_pulse_len", u_if.rsp_valid, 0);
               m_rdy_chk = 0;
            end
            if (m_act) m_k++;
            if (!u_if.lpc_frame && u_if.lpc_ad_oe &&
                u_if.lpc_ad_out == 4'h0) begin
               m_act = 1; m_k = 0;
            end
            if (m_act && m_k < 400) begin
               m_fr[m_k]  = u_if.lpc_frame;
               m_oe[m_k]  = u_if.lpc_ad_oe;
               m_rdy[m_k] = u_if.req_ready;
               m_ad[m_k]  = u_if.lpc_ad_out;
            end
            if (u_if.rsp_valid) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_rsp", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  chk("rsp_data", u_if.rsp_data, e.data);
                  chk("rsp_status", u_if.rsp_status, e.st);
                  chk("latency", m_k, e.lat);
                  first = -1;
                  for (int k = 0; k <= e.lat && k < 400; k++) begin
                     if (first < 0 &&
                         (m_fr[k] !== e.fr[k] || m_oe[k] !== e.oe[k] ||
                          m_rdy[k] !== e.rdy[k] ||
                          (e.oe[k] && m_ad[k] !== e.ad[k])))
                        first = k;
                  end
                  chk("bus_trace_first_bad", first, -1);
               end
               m_act = 0;
               m_rdy_chk = 1;
               done_cnt++;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] invs [5];
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
      int ss, k, n, m, c0;
      invs = '{4'hF, 4'h3, 4'h9, 4'h1, 4'hC};
      u_if.req_valid = 1'b0;
      u_if.req_write = 1'b0;
      u_if.req_addr  = '0;
      u_if.req_data  = '0;
      clr_per();
      repeat (3) @(negedge clk);
      chk("rst_frame", u_if.lpc_frame, 1);
      chk("rst_oe", u_if.lpc_ad_oe, 0);
      chk("rst_ad", u_if.lpc_ad_out, 4'hF);
      chk("rst_ready", u_if.req_ready, 1);
      chk("rst_valid", u_if.rsp_valid, 0);
      chk("rst_data", u_if.rsp_data, 0);
      chk("rst_status", u_if.rsp_status, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      clr_per(); per[10] = 4'h0;
      issue(1'b1, 16'h7fe5, 8'h6c, 1'b0);
      clr_per(); per[8] = 4'h0; per[9] = 4'h5; per[10] = 4'hA;
      issue(1'b0, 16'h002e, 8'h00, 1'b0);
      clr_per();
      per[8] = 4'h6; per[9] = 4'h6; per[10] = 4'h6;
      per[11] = 4'h0; per[12] = 4'h7; per[13] = 4'h1;
      issue(1'b0, 16'h1234, 8'h00, 1'b1);
      clr_per();
      issue(1'b1, 16'h0080, 8'h99, 1'b0);
      clr_per(); per[8] = 4'hA; per[9] = 4'hC; per[10] = 4'h3;
      issue(1'b0, 16'hbeef, 8'h00, 1'b0);
      clr_per();
      for (int i = 8; i < 8 + 255; i++) per[i] = 4'h5;
      issue(1'b0, 16'h4321, 8'h00, 1'b0);
      clr_per();
      for (int i = 17; i < 17 + 7; i++) per[i] = 4'h3;
      per[24] = 4'h5;
      for (int i = 25; i < 25 + 7; i++) per[i] = 4'hF;
      per[32] = 4'h0;
      issue(1'b1, 16'hffff, 8'h00, 1'b0);

      clr_per(); per[10] = 4'h0;
      sbq.push_back(model(1'b1, 16'h1234, 8'h55));
      @(posedge clk); #1;
      u_if.req_valid = 1'b1;
      u_if.req_write = 1'b1;
      u_if.req_addr  = 16'h1234;
      u_if.req_data  = 8'h55;
      @(posedge clk); #1;
      u_if.req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!(m_act && m_k == 4) && n < 100);
      chk("reach_addr1", m_k, 4);
      rst_n = 1'b0;
      #1;
      chk("midrst_frame", u_if.lpc_frame, 1);
      chk("midrst_oe", u_if.lpc_ad_oe, 0);
      chk("midrst_ready", u_if.req_ready, 1);
      sbq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      c0 = done_cnt;
      repeat (20) @(negedge clk);
      #2;
      chk("no_rsp_after_reset", done_cnt - c0, 0);
      clr_per(); per[10] = 4'h0;
      issue(1'b1, 16'h5a5a, 8'hc3, 1'b0);

      for (int t = 0; t < 40; t++) begin
         w = 1'($urandom_range(0, 1));
         a = 16'($urandom);
         d = 8'($urandom);
         clr_per();
         ss = w ? 10 : 8;
         n = $urandom_range(0, 6);
         k = ss;
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1)
               per[k] = ($urandom_range(0, 1) == 1) ? 4'h5 : 4'h6;
            else
               per[k] = invs[$urandom_range(0, 4)];
            k++;
         end
         m = $urandom_range(0, 6);
         if (m < 4)      per[k] = 4'h0;
         else if (m < 6) per[k] = 4'hA;
         per[k+1] = 4'($urandom);
         per[k+2] = 4'($urandom);
         issue(w, a, d, 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      chk("sb_leftover", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
